multiplexor_module: RTL and testbench



---
 rtl/multiplexor_module.sv | 68 ++++++
 tb/tb_multiplexor_module.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_module.sv
// Registered operand-select / compute stage: picks one of four 8-bit operands,
// their sum, or one of two 8x8 products, and registers it with a valid flag.
module multiplexor_module (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  C,
  input  logic [7:0]  D,
  input  logic [2:0]  SEL,
  output logic [15:0] R,
  output logic        en
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_c;
  logic [15:0] w_d;
  logic [15:0] w_sum;
  logic [15:0] w_prod_ab;
  logic [15:0] w_prod_cd;
  logic [15:0] w_result;
  logic        w_valid;
  logic [15:0] r_result;
  logic        r_en;

  // Widen before the arithmetic so the sum and the full products never truncate.
  assign w_a       = {8'h00, A};
  assign w_b       = {8'h00, B};
  assign w_c       = {8'h00, C};
  assign w_d       = {8'h00, D};
  assign w_sum     = w_a + w_b + w_c + w_d;
  assign w_prod_ab = w_a * w_b;
  assign w_prod_cd = w_c * w_d;

  // The default arm also absorbs unknown select values as reserved.
  always_comb begin
    w_result = 16'h0000;
    w_valid  = 1'b0;
    case (SEL)
      3'b000: begin w_result = w_a;       w_valid = 1'b1; end
      3'b001: begin w_result = w_b;       w_valid = 1'b1; end
      3'b010: begin w_result = w_c;       w_valid = 1'b1; end
      3'b011: begin w_result = w_d;       w_valid = 1'b1; end
      3'b100: begin w_result = w_sum;     w_valid = 1'b1; end
      3'b101: begin w_result = w_prod_ab; w_valid = 1'b1; end
      3'b110: begin w_result = w_prod_cd; w_valid = 1'b1; end
      default: begin
        w_result = 16'h0000;
        w_valid  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 16'h0000;
      r_en     <= 1'b0;
    end else begin
      r_result <= w_result;
      r_en     <= w_valid;
    end
  end

  assign R  = r_result;
  assign en = r_en;

endmodule

// File: tb/tb_multiplexor_module.sv
// Self-checking bench for multiplexor_module: directed scenarios plus a
// randomized run compared against a behavioural model of the select rules.
module tb_multiplexor_module;

  logic        clk;
  logic        rst;
  logic [7:0]  A, B, C, D;
  logic [2:0]  SEL;
  logic [15:0] R;
  logic        en;

  int checks = 0;
  int errors = 0;

  multiplexor_module dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .SEL(SEL), .R(R), .en(en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: {en, R} from plain integer arithmetic.
  function automatic logic [16:0] model(input int unsigned a, b, c, d, input int unsigned sel);
    int unsigned r;
    bit v;
    v = 1'b1;
    case (sel)
      0: r = a;
      1: r = b;
      2: r = c;
      3: r = d;
      4: r = a + b + c + d;
      5: r = a * b;
      6: r = c * d;
      default: begin r = 0; v = 1'b0; end
    endcase
    return {v, r[15:0]};
  endfunction

  task automatic drive(input logic [7:0] a, b, c, d, input logic [2:0] sel);
    A = a; B = b; C = c; D = d; SEL = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(8'd0, 8'd0, 8'd0, 8'd0, 3'b000);
    checks++;
    if (R !== 16'h0000 || en !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: R=%h en=%b expected R=0000 en=0", R, en);
    end
    rst = 1'b0;
    drive(8'd255, 8'd255, 8'd0, 8'd0, 3'b101);
    checks++;
    if (R !== 16'hFE01 || en !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_product: R=%h en=%b expected R=fe01 en=1", R, en);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (R !== 16'h0000 || en !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: R=%h en=%b expected R=0000 en=0", R, en);
    end
    A = 8'd170; SEL = 3'b000;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (R !== 16'h00AA || en !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: R=%h en=%b expected R=00aa en=1", R, en);
    end
    $display("test_reset done");
  endtask

  task automatic test_passthrough;
    logic [15:0] exp_r [4] = '{16'h00AA, 16'h0001, 16'h0080, 16'h00C0};
    for (int i = 0; i < 4; i++) begin
      drive(8'd170, 8'd1, 8'd128, 8'd192, 3'(i));
      checks++;
      if (R !== exp_r[i] || en !== 1'b1) begin
        errors++;
        $display("FAIL passthrough sel=%0d: R=%h en=%b expected R=%h en=1", i, R, en, exp_r[i]);
      end
      $display("passthrough sel=%0d R=%h en=%b", i, R, en);
    end
  endtask

  task automatic test_sum;
    drive(8'd170, 8'd1, 8'd128, 8'd192, 3'b100);
    checks++;
    if (R !== 16'h01EB || en !== 1'b1) begin
      errors++;
      $display("FAIL sum_mixed: R=%h en=%b expected R=01eb en=1", R, en);
    end
    $display("sum mixed R=%h en=%b", R, en);
    drive(8'd255, 8'd255, 8'd255, 8'd255, 3'b100);
    checks++;
    if (R !== 16'h03FC || en !== 1'b1) begin
      errors++;
      $display("FAIL sum_max: R=%h en=%b expected R=03fc en=1", R, en);
    end
    $display("sum max R=%h en=%b", R, en);
  endtask

  task automatic test_products;
    drive(8'd255, 8'd170, 8'd0, 8'd0, 3'b101);
    checks++;
    if (R !== 16'hA956 || en !== 1'b1) begin
      errors++;
      $display("FAIL prod_ab: R=%h en=%b expected R=a956 en=1", R, en);
    end
    $display("product A*B R=%h en=%b", R, en);
    drive(8'd0, 8'd0, 8'd128, 8'd192, 3'b110);
    checks++;
    if (R !== 16'h6000 || en !== 1'b1) begin
      errors++;
      $display("FAIL prod_cd: R=%h en=%b expected R=6000 en=1", R, en);
    end
    $display("product C*D R=%h en=%b", R, en);
    drive(8'd255, 8'd255, 8'd3, 8'd7, 3'b101);
    checks++;
    if (R !== 16'hFE01 || en !== 1'b1) begin
      errors++;
      $display("FAIL prod_max: R=%h en=%b expected R=fe01 en=1", R, en);
    end
    $display("product max R=%h en=%b", R, en);
  endtask

  task automatic test_reserved;
    drive(8'd255, 8'd170, 8'd1, 8'd128, 3'b111);
    checks++;
    if (R !== 16'h0000 || en !== 1'b0) begin
      errors++;
      $display("FAIL reserved: R=%h en=%b expected R=0000 en=0", R, en);
    end
    $display("reserved R=%h en=%b", R, en);
    drive(8'd255, 8'd170, 8'd1, 8'd128, 3'b101);
    checks++;
    if (R !== 16'hA956 || en !== 1'b1) begin
      errors++;
      $display("FAIL reserved_recover: R=%h en=%b expected R=a956 en=1", R, en);
    end
    $display("after reserved R=%h en=%b", R, en);
  endtask

  // Alternating select: the output must lag exactly one edge and never skip.
  task automatic test_back_to_back;
    logic [15:0] prev_r;
    logic [15:0] exp_r;
    logic [2:0]  sel;
    prev_r = R;
    for (int i = 0; i < 8; i++) begin
      sel   = (i % 2 == 0) ? 3'b000 : 3'b011;
      exp_r = (i % 2 == 0) ? 16'h0011 : 16'h0022;
      A = 8'h11; B = 8'h00; C = 8'h00; D = 8'h22; SEL = sel;
      #2;
      checks++;
      if (R !== prev_r) begin
        errors++;
        $display("FAIL latency_hold cycle=%0d: R=%h expected R=%h", i, R, prev_r);
      end
      @(posedge clk);
      #1;
      checks++;
      if (R !== exp_r || en !== 1'b1) begin
        errors++;
        $display("FAIL latency_update cycle=%0d: R=%h en=%b expected R=%h en=1", i, R, en, exp_r);
      end
      $display("back_to_back cycle=%0d sel=%0d R=%h", i, sel, R);
      prev_r = exp_r;
    end
  endtask

  task automatic test_random;
    logic [16:0] exp_v;
    logic [7:0]  a, b, c, d;
    logic [2:0]  sel;
    for (int i = 0; i < 300; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      c   = 8'($urandom_range(0, 255));
      d   = 8'($urandom_range(0, 255));
      sel = 3'($urandom_range(0, 7));
      if (i % 25 == 0) begin
        a = 8'hFF; b = 8'hFF; c = 8'hFF; d = 8'hFF;
      end
      exp_v = model(a, b, c, d, sel);
      drive(a, b, c, d, sel);
      checks++;
      if (R !== exp_v[15:0] || en !== exp_v[16]) begin
        errors++;
        $display("FAIL random i=%0d sel=%0d a=%0d b=%0d c=%0d d=%0d: R=%h en=%b expected R=%h en=%b",
                 i, sel, a, b, c, d, R, en, exp_v[15:0], exp_v[16]);
      end
      $display("random i=%0d sel=%0d R=%h en=%b", i, sel, R, en);
    end
  endtask

  initial begin
    rst = 1'b1;
    A = 8'd0; B = 8'd0; C = 8'd0; D = 8'd0; SEL = 3'b000;
    test_reset;
    test_passthrough;
    test_sum;
    test_products;
    test_reserved;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
